// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: parity-width sizing, decode status and Hamming
// position to data-bit mapping (lowest data position lands on the data MSB).
package ecc_pkg;

  typedef enum logic [1:0] {
    CLEAN,
    CORRECTED,
    UNCORR
  } ecc_status_t;

  function automatic int par_w(input int data_w);
    int p = 1;
    while ((1 << p) < (data_w + p + 1)) p = p + 1;
    return p;
  endfunction

  // Returns -1 for parity (power-of-two) positions.
  function automatic int pos_to_didx(input int pos, input int data_w);
    int idx = data_w - 1;
    if ((pos & (pos - 1)) == 0) return -1;
    for (int i = 1; i < pos; i++)
      if ((i & (i - 1)) != 0) idx = idx - 1;
    return idx;
  endfunction

endpackage

// File: rtl/secded_decoder_pipe_if.sv
// Codeword in / corrected word out handshake bundle for the SECDED decoder.
// slave = decoder side, master = source/sink side.
interface secded_decoder_pipe_if
  import ecc_pkg::*;
#(
  parameter int DATA_W = 4
);
  localparam int PAR_W  = par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_corr;
  logic              err_uncorr;
  logic [PAR_W-1:0]  err_pos;

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, err_corr, err_uncorr, err_pos
  );

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, err_corr, err_uncorr, err_pos
  );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome (XOR of set positions) and overall parity q.
// Shared with the encoder-side checker.
module hamming_syndrome
  import ecc_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W+par_w(DATA_W):0]  i_code,
  output logic [par_w(DATA_W)-1:0]       o_s,
  output logic                           o_q
);
  localparam int PAR_W  = par_w(DATA_W);
  localparam int N      = DATA_W + PAR_W;
  localparam int CODE_W = N + 1;

  always_comb begin
    o_s = '0;
    for (int p = 1; p <= N; p++)
      if (i_code[CODE_W-p]) o_s = o_s ^ PAR_W'(p);
  end

  assign o_q = ^i_code;
endmodule

// File: rtl/secded_decoder_pipe.sv
// Two-stage SECDED decoder/corrector with valid/ready on both sides; each stage holds while downstream stalls.
// Error counters are built only when SECDED_ERR_CNT_EN is defined.
module secded_decoder_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  secded_decoder_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);
  localparam int PAR_W  = par_w(DATA_W);
  localparam int N      = DATA_W + PAR_W;
  localparam int CODE_W = N + 1;

  logic [PAR_W-1:0]  w_s;
  logic              w_q;
  logic              w_s1_move;
  logic              w_in_rdy;

  logic              r_s1_vld;
  logic [CODE_W-1:0] r_s1_code;
  logic [PAR_W-1:0]  r_s1_s;
  logic              r_s1_q;

  logic              r_s2_vld;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_corr;
  logic              r_s2_uncorr;
  logic [PAR_W-1:0]  r_s2_pos;

  ecc_status_t       w_status;
  logic [CODE_W-1:0] w_fixed;
  logic [DATA_W-1:0] w_data;
  logic              w_unused_par;

  hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
    .i_code (bus.code_in),
    .o_s    (w_s),
    .o_q    (w_q)
  );

  assign w_s1_move    = !r_s2_vld || bus.out_ready;
  assign w_in_rdy     = !r_s1_vld || w_s1_move;
  assign bus.in_ready = w_in_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_code <= '0;
      r_s1_s    <= '0;
      r_s1_q    <= 1'b0;
    end else if (w_in_rdy) begin
      r_s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_code <= bus.code_in;
        r_s1_s    <= w_s;
        r_s1_q    <= w_q;
      end
    end
  end

  // s=0 with q=1 lands in CORRECTED but matches no position, so data is untouched.
  always_comb begin
    w_status = CLEAN;
    if (r_s1_q)
      w_status = (int'(r_s1_s) <= N) ? CORRECTED : UNCORR;
    else if (r_s1_s != '0)
      w_status = UNCORR;
    w_fixed = r_s1_code;
    if (w_status == CORRECTED)
      for (int p = 1; p <= N; p++)
        if (r_s1_s == PAR_W'(p)) w_fixed[CODE_W-p] = ~r_s1_code[CODE_W-p];
  end

  for (genvar p = 1; p <= N; p++) begin : g_ext
    if (pos_to_didx(p, DATA_W) >= 0) begin : g_d
      assign w_data[pos_to_didx(p, DATA_W)] = w_fixed[CODE_W-p];
    end
  end

  assign w_unused_par = ^w_fixed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_vld    <= 1'b0;
      r_s2_data   <= '0;
      r_s2_corr   <= 1'b0;
      r_s2_uncorr <= 1'b0;
      r_s2_pos    <= '0;
    end else if (w_s1_move) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data   <= w_data;
        r_s2_corr   <= (w_status == CORRECTED);
        r_s2_uncorr <= (w_status == UNCORR);
        r_s2_pos    <= r_s1_s;
      end
    end
  end

  assign bus.out_valid  = r_s2_vld;
  assign bus.data_out   = r_s2_data;
  assign bus.err_corr   = r_s2_corr;
  assign bus.err_uncorr = r_s2_uncorr;
  assign bus.err_pos    = r_s2_pos;

`ifdef SECDED_ERR_CNT_EN
  logic             w_hs;
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  assign w_hs = r_s2_vld && bus.out_ready;

  // Clear wins over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_hs) begin
      if (r_s2_corr && (r_corr_cnt != '1))
        r_corr_cnt <= r_corr_cnt + 1'b1;
      if (r_s2_uncorr && (r_uncorr_cnt != '1))
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
    end
  end

  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign corr_cnt         = '0;
  assign uncorr_cnt       = '0;
`endif
endmodule
